alu_share_sequencer: RTL
========================

ALU_SHARE_SEQUENCER -- requirements
Module: alu_share_sequencer

Interface
REQ-001 Parameter: SETTLE, default 2, number of whole clock cycles the ALU operands are held stable before the result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; held high until done0.
REQ-005 a0, b0  input  32 each  requester 0 operands A and B.
REQ-006 ctl0  input  3  requester 0 ALU control: 000 add, 001 xor, 010 sub, 011 slt.
REQ-007 req1, a1, b1, ctl1  input  1/32/32/3  requester 1 equivalents of REQ-004..006.
REQ-008 alu_a, alu_b  output  32 each  registered operands driven to the shared ALU BussA/BussB.
REQ-009 alu_ctl  output  3  registered control driven to the shared ALU ALUControl.
REQ-010 alu_out  input  32  ALU Output.
REQ-011 alu_carry, alu_zero, alu_ovf, alu_neg  input  1 each  ALU CarryOut, zero, overflow, negative.
REQ-012 busy  output  1  high in WAIT and RESP states.
REQ-013 owner  output  1  index of the requester currently or most recently granted.
REQ-014 done0, done1  output  1 each  one-cycle completion pulse to the respective requester.
REQ-015 result  output  32  captured alu_out of the last completed operation.
REQ-016 res_carry, res_zero, res_ovf, res_neg  output  1 each  captured flags of the last completed operation.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-018 In IDLE with no request, the state SHALL stay IDLE and alu_a/alu_b/alu_ctl SHALL hold their previous values.
REQ-019 In IDLE with exactly one reqN high, the block SHALL latch aN/bN/ctlN into alu_a/alu_b/alu_ctl, set owner=N, load the settle counter with SETTLE-1, and enter WAIT on the same edge.
REQ-020 In IDLE with both requests high, the grant SHALL go to the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-021 In WAIT, the counter SHALL decrement each cycle; on the edge where it reads 0, result and res_* SHALL capture alu_out and ALU flags and the state SHALL become RESP.
REQ-022 In RESP, done[owner] SHALL be high for exactly that one cycle; the other done SHALL stay low; the state SHALL return to IDLE unconditionally on the next edge.
REQ-023 A request is accepted only in IDLE; requests present during WAIT or RESP SHALL be ignored until IDLE, so a requester dropping req after seeing done is never re-served.
REQ-024 Latency: acceptance edge E0 -> done high during the cycle after edge E0+SETTLE; throughput is one operation per SETTLE+2 cycles.
REQ-025 Deassertion of req[owner] or changes of its operands during WAIT SHALL NOT abort or alter the operation; done still pulses.
REQ-026 alu_ctl SHALL pass all 3 bits unmodified; codes 1xx are forwarded without checking.
REQ-027 result/res_* SHALL hold their values until the next capture.
REQ-028 The round-robin pointer SHALL update only on acceptance, never on completion.

Reset
REQ-029 Asserting reset SHALL immediately force: state IDLE, busy=0, done0=done1=0, owner=0, alu_a=alu_b=0, alu_ctl=000, result=0, res_*=0, counter=0, round-robin pointer favouring requester 0.
REQ-030 Reset during WAIT or RESP SHALL abandon the operation with no done pulse; after release the first IDLE cycle arbitrates afresh.

Verification
REQ-031 SETTLE=2, req0 with a0=5, b0=3, ctl0=000 -> done0 high exactly 3 edges after acceptance, result=8, res_zero=0, res_neg=0.
REQ-032 req1 with a1=3, b1=5, ctl1=010 -> result=0xFFFFFFFE, res_neg=1, done1 pulses once, done0 stays 0.
REQ-033 req0 and req1 both held high continuously after reset -> grants alternate 0,1,0,1 (owner sequence), each done pulse one cycle, one op per 4 cycles.
REQ-034 req0 with a0=0x0000000F, b0=0x0000000F, ctl0=001 -> result=0, res_zero=1; then ctl0=011 with a0=2, b0=7 -> result=1.
REQ-035 Reset asserted mid-WAIT of an add -> outputs immediately reach REQ-029 values, no done pulse; after release a pending req1 is accepted on the first IDLE edge.
REQ-036 SETTLE=1 and SETTLE=15 builds -> done latency 2 and 16 edges respectively, results match REQ-031.

Source files
------------

// File: rtl/alu_share_sequencer.sv
// Shares one external ALU between two requesters. Accepted operands are held
// stable for SETTLE cycles, then the result and flags are captured and a
// one-cycle done pulse goes back to the requester that was served.
module alu_share_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [2:0]  ctl0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  ctl1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctl,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_neg,
  output logic        busy,
  output logic        owner,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        res_carry,
  output logic        res_zero,
  output logic        res_ovf,
  output logic        res_neg
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prio_q, prio_d;   // requester that wins the next tie
  logic            grant;
  logic            owner_d, busy_d, done0_d, done1_d;
  logic [31:0]     alu_a_d, alu_b_d, result_d;
  logic [2:0]      alu_ctl_d;
  logic [3:0]      flags_d;

  // Next-state, arbitration, operand latch and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    grant     = 1'b0;
    owner_d   = owner;
    alu_a_d   = alu_a;
    alu_b_d   = alu_b;
    alu_ctl_d = alu_ctl;
    result_d  = result;
    flags_d   = {res_carry, res_zero, res_ovf, res_neg};

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant     = (req0 && req1) ? prio_q : req1;
          owner_d   = grant;
          alu_a_d   = grant ? a1   : a0;
          alu_b_d   = grant ? b1   : b0;
          alu_ctl_d = grant ? ctl1 : ctl0;
          cnt_d     = CNT_LOAD;
          prio_d    = ~grant;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          result_d = alu_out;
          flags_d  = {alu_carry, alu_zero, alu_ovf, alu_neg};
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    done0_d = (state_d == RESP) && !owner_d;
    done1_d = (state_d == RESP) &&  owner_d;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctl   <= '0;
      result    <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_ovf   <= 1'b0;
      res_neg   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      owner     <= owner_d;
      busy      <= busy_d;
      done0     <= done0_d;
      done1     <= done1_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_ctl   <= alu_ctl_d;
      result    <= result_d;
      res_carry <= flags_d[3];
      res_zero  <= flags_d[2];
      res_ovf   <= flags_d[1];
      res_neg   <= flags_d[0];
    end
  end

endmodule
